// File: rtl/spi_lcd_window_receiver.sv
// SPI LCD-controller command receiver: decodes CASET/RASET/RAMWR/COLMOD byte
// streams sampled in the system clock domain and emits BGR555 frame writes.
module spi_lcd_window_receiver #(
    parameter int FRAME_W = 240,
    parameter int FRAME_H = 160,
    parameter int ADDR_W  = 16
) (
    input  logic              IwClk,
    input  logic              IwRstn,
    input  logic              IwCSn,
    input  logic              IwSCLK,
    input  logic              IwSDI,
    input  logic              IwDC,
    output logic [ADDR_W-1:0] ObFrameMemWriteAddr,
    output logic [15:0]       ObFrameMemWriteData,
    output logic              OwFrameMemWE,
    output logic              OwFrameStart,
    output logic              OwFrameDone
);

    localparam logic [15:0] COL_MAX = 16'(FRAME_W - 1);
    localparam logic [15:0] ROW_MAX = 16'(FRAME_H - 1);

    typedef enum logic [2:0] {
        CTX_IDLE, CTX_CASET, CTX_RASET, CTX_RAMWR, CTX_COLMOD
    } ctx_t;

    ctx_t        ctx, ctx_next;
    logic [1:0]  csn_s, sdi_s, dc_s;
    logic [2:0]  sclk_s;
    logic        rise_p1, sdi_p1, dc_p1;
    logic [2:0]  bit_cnt, par_idx;
    logic [1:0]  pix_idx;
    logic [6:0]  shreg;
    logic [7:0]  par_b0, par_b1, par_b2, pix_b0, pix_b1;
    logic [15:0] sc, ec, sr, er, col, row;
    logic        fmt666;

    logic [7:0]        byte_val;
    logic              byte_done, is_cmd, is_data, pix_last;
    logic [15:0]       lim, win_start, win_end_raw, win_end, pix_data;
    logic [ADDR_W-1:0] pix_addr;

    function automatic logic [15:0] clamp_to(input logic [15:0] v, input logic [15:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // Synchronisers (stage 1-2) and registered SCLK rising-edge detect (stage 3)
    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn) begin
            csn_s   <= 2'b11;
            sclk_s  <= 3'b000;
            sdi_s   <= 2'b00;
            dc_s    <= 2'b00;
            rise_p1 <= 1'b0;
            sdi_p1  <= 1'b0;
            dc_p1   <= 1'b0;
        end else begin
            csn_s   <= {csn_s[0], IwCSn};
            sclk_s  <= {sclk_s[1:0], IwSCLK};
            sdi_s   <= {sdi_s[0], IwSDI};
            dc_s    <= {dc_s[0], IwDC};
            rise_p1 <= sclk_s[1] & ~sclk_s[2] & ~csn_s[1];
            sdi_p1  <= sdi_s[1];
            dc_p1   <= dc_s[1];
        end
    end

    // Byte, window and pixel decode for the current detected SCLK edge
    always_comb begin
        byte_val    = {shreg, sdi_p1};
        byte_done   = rise_p1 && !csn_s[1] && (bit_cnt == 3'd7);
        is_cmd      = byte_done && !dc_p1;
        is_data     = byte_done && dc_p1;
        lim         = (ctx == CTX_CASET) ? COL_MAX : ROW_MAX;
        win_start   = clamp_to({par_b0, par_b1}, lim);
        win_end_raw = clamp_to({par_b2, byte_val}, lim);
        win_end     = (win_end_raw < win_start) ? win_start : win_end_raw;
        pix_last    = fmt666 ? (pix_idx == 2'd2) : (pix_idx == 2'd1);
        if (fmt666)
            pix_data = {1'b0, byte_val[7:3], pix_b1[7:3], pix_b0[7:3]};
        else
            pix_data = {1'b0, byte_val[4:0], pix_b0[2:0], byte_val[7:6], pix_b0[7:3]};
        pix_addr = ADDR_W'(row) * ADDR_W'(FRAME_W) + ADDR_W'(col);
    end

    // Command context state register
    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn) ctx <= CTX_IDLE;
        else         ctx <= ctx_next;
    end

    // Command context next state: every command byte re-selects the context
    always_comb begin
        ctx_next = ctx;
        if (is_cmd) begin
            case (byte_val)
                8'h2A:         ctx_next = CTX_CASET;
                8'h2B:         ctx_next = CTX_RASET;
                8'h2C, 8'h3C:  ctx_next = CTX_RAMWR;
                8'h3A:         ctx_next = CTX_COLMOD;
                default:       ctx_next = CTX_IDLE;
            endcase
        end
    end

    // Stage 4: byte assembly, parameter commit, pixel write and pointer advance
    always_ff @(posedge IwClk or negedge IwRstn) begin
        if (!IwRstn) begin
            bit_cnt <= '0; par_idx <= '0; pix_idx <= '0; shreg <= '0;
            par_b0 <= '0; par_b1 <= '0; par_b2 <= '0; pix_b0 <= '0; pix_b1 <= '0;
            sc <= '0; ec <= COL_MAX; sr <= '0; er <= ROW_MAX;
            col <= '0; row <= '0; fmt666 <= 1'b0;
            ObFrameMemWriteAddr <= '0; ObFrameMemWriteData <= '0;
            OwFrameMemWE <= 1'b0; OwFrameStart <= 1'b0; OwFrameDone <= 1'b0;
        end else begin
            OwFrameMemWE <= 1'b0;
            OwFrameStart <= 1'b0;
            OwFrameDone  <= 1'b0;
            if (csn_s[1]) begin
                bit_cnt <= '0;
                par_idx <= '0;
                pix_idx <= '0;
            end else if (rise_p1) begin
                shreg   <= byte_val[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (is_cmd) begin
                    par_idx <= '0;
                    pix_idx <= '0;
                    if (byte_val == 8'h2C) begin
                        col          <= sc;
                        row          <= sr;
                        OwFrameStart <= 1'b1;
                    end
                end else if (is_data) begin
                    case (ctx)
                        CTX_CASET, CTX_RASET: begin
                            case (par_idx)
                                3'd0: par_b0 <= byte_val;
                                3'd1: par_b1 <= byte_val;
                                3'd2: par_b2 <= byte_val;
                                3'd3: begin
                                    if (ctx == CTX_CASET) begin
                                        sc <= win_start; ec <= win_end;
                                    end else begin
                                        sr <= win_start; er <= win_end;
                                    end
                                end
                                default: ;
                            endcase
                            if (par_idx != 3'd4) par_idx <= par_idx + 3'd1;
                        end
                        CTX_COLMOD: begin
                            if (par_idx == 3'd0) begin
                                if (byte_val[3:0] == 4'h5)      fmt666 <= 1'b0;
                                else if (byte_val[3:0] == 4'h6) fmt666 <= 1'b1;
                                par_idx <= 3'd1;
                            end
                        end
                        CTX_RAMWR: begin
                            if (pix_last) begin
                                pix_idx             <= '0;
                                OwFrameMemWE        <= 1'b1;
                                ObFrameMemWriteAddr <= pix_addr;
                                ObFrameMemWriteData <= pix_data;
                                if (col < ec) begin
                                    col <= col + 16'd1;
                                end else begin
                                    col <= sc;
                                    if (row < er) begin
                                        row <= row + 16'd1;
                                    end else begin
                                        row         <= sr;
                                        OwFrameDone <= 1'b1;
                                    end
                                end
                            end else begin
                                if (pix_idx == 2'd0) pix_b0 <= byte_val;
                                else                 pix_b1 <= byte_val;
                                pix_idx <= pix_idx + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
